ntt_bfu_cfg: RTL and testbench

- Parametrised, mode-selectable modular butterfly unit for the NTT/INTT datapath.
- Runtime per-sample mode: Cooley-Tukey (forward NTT), Gentleman-Sande (inverse NTT) or bypass.
- Valid-tagged pipeline with global stall enable. Fixed latency, identical in every mode, so mode may change every cycle.
- Contains its own pipelined modular multiplier, parametrised in modulus and depth.

---
 rtl/ntt_bfu_cfg.sv | 148 ++++++++++++++
 tb/tb_ntt_bfu_cfg.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_bfu_cfg.sv
// Mode-selectable NTT/INTT butterfly (CT / GS / bypass) with an embedded Barrett
// modular multiplier; fixed latency MUL_LAT+2 in every mode, global stall via en.
module ntt_bfu_cfg #(
    parameter int DATA_W  = 12,
    parameter int Q       = 3329,
    parameter int MUL_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              in_valid,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] u,
    input  logic [DATA_W-1:0] v,
    input  logic [DATA_W-1:0] w,
    output logic              out_valid,
    output logic [DATA_W-1:0] bf_upper,
    output logic [DATA_W-1:0] bf_lower
);

    localparam int PW = 2 * DATA_W;
    localparam logic [DATA_W:0] Q_S = (DATA_W + 1)'(Q);
    localparam logic [PW:0] Q_P = (PW + 1)'(Q);
    localparam longint unsigned BARRETT_L = (longint'(1) << PW) / longint'(Q);
    localparam logic [PW:0] BARRETT_M = (PW + 1)'(BARRETT_L);
    localparam logic [1:0] MODE_CT = 2'b00;
    localparam logic [1:0] MODE_GS = 2'b01;

    function automatic logic [DATA_W-1:0] mod_add(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        logic [DATA_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= Q_S) s = s - Q_S;
        return s[DATA_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] mod_sub(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        logic [DATA_W:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (a < b) d = d + Q_S;
        return d[DATA_W-1:0];
    endfunction

    // Barrett with k = 2*DATA_W: the quotient estimate is at most one short,
    // so a single conditional subtract lands in [0, Q-1].
    function automatic logic [DATA_W-1:0] mod_reduce(input logic [PW-1:0] p);
        logic [2*PW:0] t;
        logic [PW-1:0] qh;
        logic [PW:0]   r;
        t  = {{(PW + 1){1'b0}}, p} * {{PW{1'b0}}, BARRETT_M};
        qh = t[2*PW-1:PW];
        r  = {1'b0, p} - ({1'b0, qh} * Q_P);
        if (r >= Q_P) r = r - Q_P;
        return r[DATA_W-1:0];
    endfunction

    logic [DATA_W-1:0] u_q, v_q, w_q;
    logic [1:0]        mode_q;
    logic              vld_q;
    logic [DATA_W-1:0] dl_a_q [1:MUL_LAT];
    logic [DATA_W-1:0] dl_b_q [1:MUL_LAT];
    logic [1:0]        dl_m_q [1:MUL_LAT];
    logic              dl_v_q [1:MUL_LAT];
    logic [PW-1:0]     mul_q  [1:MUL_LAT];
    logic [PW-1:0]     mul_d  [1:MUL_LAT];
    logic [DATA_W-1:0] pre_a_d, mul_op_d, res_d;
    logic [PW-1:0]     prod_d;
    logic [DATA_W-1:0] up_d, lo_d, up_q, lo_q;
    logic              vld_out_q;

    // GS does its add/sub ahead of the multiplier; CT multiplies v raw.
    always_comb begin
        mul_op_d = (mode_q == MODE_GS) ? mod_sub(u_q, v_q) : v_q;
        pre_a_d  = (mode_q == MODE_GS) ? mod_add(u_q, v_q) : u_q;
        prod_d   = {{DATA_W{1'b0}}, mul_op_d} * {{DATA_W{1'b0}}, w_q};
    end

    // Product registered first, reduced in the next stage, then delayed.
    always_comb begin
        mul_d[1] = (MUL_LAT == 1) ? PW'(mod_reduce(prod_d)) : prod_d;
        for (int k = 2; k <= MUL_LAT; k++) begin
            mul_d[k] = (k == 2) ? PW'(mod_reduce(mul_q[1])) : mul_q[k-1];
        end
    end

    assign res_d = mul_q[MUL_LAT][DATA_W-1:0];

    always_comb begin
        up_d = dl_a_q[MUL_LAT];
        lo_d = dl_b_q[MUL_LAT];
        case (dl_m_q[MUL_LAT])
            MODE_CT: begin
                up_d = mod_sub(dl_a_q[MUL_LAT], res_d);
                lo_d = mod_add(dl_a_q[MUL_LAT], res_d);
            end
            MODE_GS: lo_d = res_d;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            u_q       <= '0;
            v_q       <= '0;
            w_q       <= '0;
            mode_q    <= '0;
            vld_q     <= 1'b0;
            for (int k = 1; k <= MUL_LAT; k++) begin
                dl_a_q[k] <= '0;
                dl_b_q[k] <= '0;
                dl_m_q[k] <= '0;
                dl_v_q[k] <= 1'b0;
                mul_q[k]  <= '0;
            end
            up_q      <= '0;
            lo_q      <= '0;
            vld_out_q <= 1'b0;
        end else if (en) begin
            u_q       <= u;
            v_q       <= v;
            w_q       <= w;
            mode_q    <= mode;
            vld_q     <= in_valid;
            dl_a_q[1] <= pre_a_d;
            dl_b_q[1] <= v_q;
            dl_m_q[1] <= mode_q;
            dl_v_q[1] <= vld_q;
            for (int k = 2; k <= MUL_LAT; k++) begin
                dl_a_q[k] <= dl_a_q[k-1];
                dl_b_q[k] <= dl_b_q[k-1];
                dl_m_q[k] <= dl_m_q[k-1];
                dl_v_q[k] <= dl_v_q[k-1];
            end
            for (int k = 1; k <= MUL_LAT; k++) begin
                mul_q[k] <= mul_d[k];
            end
            up_q      <= up_d;
            lo_q      <= lo_d;
            vld_out_q <= dl_v_q[MUL_LAT];
        end
    end

    assign out_valid = vld_out_q;
    assign bf_upper  = up_q;
    assign bf_lower  = lo_q;

endmodule

// File: tb/tb_ntt_bfu_cfg.sv
// Self-checking bench for ntt_bfu_cfg: directed butterflies, stall, reset and a
// randomized stream against a plain-arithmetic model, plus a 14-bit parameter sweep.
module tb_ntt_bfu_cfg;

    localparam int Q  = 3329;
    localparam int L  = 5;
    localparam int SQ = 12289;
    localparam int SN = 10000;

    logic        clk = 1'b0;
    logic        rst, en, in_valid;
    logic [1:0]  mode;
    logic [11:0] u, v, w;
    logic        out_valid;
    logic [11:0] bf_upper, bf_lower;

    logic        s_en, s_valid;
    logic [1:0]  s_mode;
    logic [13:0] s_u, s_v, s_w;
    logic        s1_ov, s5_ov;
    logic [13:0] s1_up, s1_lo, s5_up, s5_lo;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int got_up[$], got_lo[$], got_t[$];

    always #5 clk = ~clk;

    ntt_bfu_cfg dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .mode(mode),
        .u(u), .v(v), .w(w), .out_valid(out_valid),
        .bf_upper(bf_upper), .bf_lower(bf_lower)
    );

    ntt_bfu_cfg #(.DATA_W(14), .Q(SQ), .MUL_LAT(1)) dut_s1 (
        .clk(clk), .rst(rst), .en(s_en), .in_valid(s_valid), .mode(s_mode),
        .u(s_u), .v(s_v), .w(s_w), .out_valid(s1_ov),
        .bf_upper(s1_up), .bf_lower(s1_lo)
    );

    ntt_bfu_cfg #(.DATA_W(14), .Q(SQ), .MUL_LAT(5)) dut_s5 (
        .clk(clk), .rst(rst), .en(s_en), .in_valid(s_valid), .mode(s_mode),
        .u(s_u), .v(s_v), .w(s_w), .out_valid(s5_ov),
        .bf_upper(s5_up), .bf_lower(s5_lo)
    );

    function automatic void ref_bf(input int m, input longint a, input longint b,
                                   input longint c, input longint q,
                                   output int up, output int lo);
        longint p;
        case (m)
            0: begin
                p  = b * c;
                up = int'((((a - p) % q) + q) % q);
                lo = int'((a + p) % q);
            end
            1: begin
                up = int'((a + b) % q);
                lo = int'((((((a - b) % q) + q) % q) * c) % q);
            end
            default: begin
                up = int'(a);
                lo = int'(b);
            end
        endcase
    endfunction

    task automatic drive(input logic val, input int m, input int a, input int b, input int c);
        in_valid = val;
        mode     = 2'(m);
        u        = 12'(a);
        v        = 12'(b);
        w        = 12'(c);
    endtask

    task automatic idle();
        drive(1'b0, $urandom_range(0, 3), $urandom_range(0, Q - 1),
              $urandom_range(0, Q - 1), $urandom_range(0, Q - 1));
    endtask

    // Advance one clock; log a result only if this edge was an enabled, out-of-reset one.
    task automatic tick();
        logic cap;
        cap = en && rst;
        @(posedge clk);
        #1;
        cyc++;
        if (cap && out_valid) begin
            got_up.push_back(int'(bf_upper));
            got_lo.push_back(int'(bf_lower));
            got_t.push_back(cyc);
        end
    endtask

    task automatic clear_got();
        got_up.delete();
        got_lo.delete();
        got_t.delete();
    endtask

    task automatic test_reset();
        int t0;
        rst = 1'b0;
        en  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, $urandom_range(0, 3), $urandom_range(0, 4095),
                  $urandom_range(0, 4095), $urandom_range(0, 4095));
            tick();
            n_checks++;
            if (out_valid !== 1'b0 || bf_upper !== 12'd0 || bf_lower !== 12'd0) begin
                n_fail++;
                $display("FAIL reset_hold: got valid=%b up=%0d lo=%0d expected 0/0/0",
                         out_valid, bf_upper, bf_lower);
            end
        end
        rst = 1'b1;
        clear_got();
        t0 = cyc;
        drive(1'b1, 0, 100, 2, 3);
        tick();
        idle();
        for (int k = 0; k < 20 && got_up.size() < 1; k++) tick();
        n_checks++;
        if (got_up.size() != 1) begin
            n_fail++;
            $display("FAIL reset_first_count: got %0d samples expected 1", got_up.size());
        end else begin
            n_checks += 2;
            if (got_t[0] - t0 != L) begin
                n_fail++;
                $display("FAIL reset_first_latency: got %0d expected %0d", got_t[0] - t0, L);
            end
            if (got_up[0] != 94 || got_lo[0] != 106) begin
                n_fail++;
                $display("FAIL reset_first_data: got %0d/%0d expected 94/106", got_up[0], got_lo[0]);
            end
        end
    endtask

    task automatic test_ct();
        int a[4]  = '{100, 3000, 5, 0};
        int b[4]  = '{2, 1000, 10, 3328};
        int c[4]  = '{3, 1, 1, 3328};
        int eu[4] = '{94, 2000, 3324, 3328};
        int el[4] = '{106, 671, 15, 1};
        int t0;
        clear_got();
        t0 = cyc;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 0, a[i], b[i], c[i]);
            tick();
        end
        idle();
        for (int k = 0; k < 20 && got_up.size() < 4; k++) tick();
        n_checks++;
        if (got_up.size() != 4) begin
            n_fail++;
            $display("FAIL ct_count: got %0d samples expected 4", got_up.size());
        end
        for (int i = 0; i < got_up.size() && i < 4; i++) begin
            n_checks += 2;
            if (got_up[i] != eu[i] || got_lo[i] != el[i]) begin
                n_fail++;
                $display("FAIL ct_data[%0d]: got %0d/%0d expected %0d/%0d",
                         i, got_up[i], got_lo[i], eu[i], el[i]);
            end
            if (got_t[i] - (t0 + i) != L) begin
                n_fail++;
                $display("FAIL ct_latency[%0d]: got %0d expected %0d", i, got_t[i] - (t0 + i), L);
            end
        end
    endtask

    task automatic test_gs();
        int a[2]  = '{10, 4};
        int b[2]  = '{4, 10};
        int c[2]  = '{17, 2};
        int eu[2] = '{14, 14};
        int el[2] = '{102, 3317};
        clear_got();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1, a[i], b[i], c[i]);
            tick();
        end
        idle();
        for (int k = 0; k < 20 && got_up.size() < 2; k++) tick();
        n_checks++;
        if (got_up.size() != 2) begin
            n_fail++;
            $display("FAIL gs_count: got %0d samples expected 2", got_up.size());
        end
        for (int i = 0; i < got_up.size() && i < 2; i++) begin
            n_checks++;
            if (got_up[i] != eu[i] || got_lo[i] != el[i]) begin
                n_fail++;
                $display("FAIL gs_data[%0d]: got %0d/%0d expected %0d/%0d",
                         i, got_up[i], got_lo[i], eu[i], el[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int m[4]  = '{0, 1, 2, 0};
        int a[4]  = '{100, 10, 7, 5};
        int b[4]  = '{2, 4, 9, 10};
        int c[4]  = '{3, 17, 0, 1};
        int eu[4] = '{94, 14, 7, 3324};
        int el[4] = '{106, 102, 9, 15};
        int t0;
        c[2] = $urandom_range(0, Q - 1);
        clear_got();
        t0 = cyc;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, m[i], a[i], b[i], c[i]);
            tick();
        end
        idle();
        for (int k = 0; k < 20 && got_up.size() < 4; k++) tick();
        n_checks++;
        if (got_up.size() != 4) begin
            n_fail++;
            $display("FAIL mixed_count: got %0d samples expected 4", got_up.size());
        end
        for (int i = 0; i < got_up.size() && i < 4; i++) begin
            n_checks += 2;
            if (got_up[i] != eu[i] || got_lo[i] != el[i]) begin
                n_fail++;
                $display("FAIL mixed_data[%0d]: got %0d/%0d expected %0d/%0d",
                         i, got_up[i], got_lo[i], eu[i], el[i]);
            end
            if (got_t[i] != t0 + i + L) begin
                n_fail++;
                $display("FAIL mixed_timing[%0d]: got cycle %0d expected %0d", i, got_t[i], t0 + i + L);
            end
        end
    endtask

    task automatic test_stall();
        int eu[4], el[4], lat[4];
        int t0, m, a, b, c;
        lat = '{L, L + 3, L + 3, L + 3};
        clear_got();
        t0 = cyc;
        for (int i = 0; i < 4; i++) begin
            m = $urandom_range(0, 3);
            a = $urandom_range(0, Q - 1);
            b = $urandom_range(0, Q - 1);
            c = $urandom_range(0, Q - 1);
            ref_bf(m, a, b, c, Q, eu[i], el[i]);
            drive(1'b1, m, a, b, c);
            tick();
        end
        idle();
        tick();
        en = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || int'(bf_upper) != eu[0] || int'(bf_lower) != el[0]) begin
                n_fail++;
                $display("FAIL stall_frozen[%0d]: got valid=%b %0d/%0d expected 1 %0d/%0d",
                         s, out_valid, bf_upper, bf_lower, eu[0], el[0]);
            end
        end
        en = 1'b1;
        for (int k = 0; k < 20 && got_up.size() < 4; k++) tick();
        n_checks++;
        if (got_up.size() != 4) begin
            n_fail++;
            $display("FAIL stall_count: got %0d samples expected 4", got_up.size());
        end
        for (int i = 0; i < got_up.size() && i < 4; i++) begin
            n_checks += 2;
            if (got_up[i] != eu[i] || got_lo[i] != el[i]) begin
                n_fail++;
                $display("FAIL stall_data[%0d]: got %0d/%0d expected %0d/%0d",
                         i, got_up[i], got_lo[i], eu[i], el[i]);
            end
            if (got_t[i] - (t0 + i) != lat[i]) begin
                n_fail++;
                $display("FAIL stall_latency[%0d]: got %0d expected %0d", i, got_t[i] - (t0 + i), lat[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_got();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, $urandom_range(0, 3), $urandom_range(0, Q - 1),
                  $urandom_range(1, Q - 1), $urandom_range(1, Q - 1));
            tick();
        end
        idle();
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre_valid: got %b expected 1", out_valid);
        end
        #3;
        rst = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || bf_upper !== 12'd0 || bf_lower !== 12'd0) begin
            n_fail++;
            $display("FAIL rstmid_async: got valid=%b up=%0d lo=%0d expected 0/0/0",
                     out_valid, bf_upper, bf_lower);
        end
        clear_got();
        for (int k = 0; k < 3; k++) tick();
        rst = 1'b1;
        for (int k = 0; k < 12; k++) tick();
        n_checks++;
        if (got_up.size() != 0) begin
            n_fail++;
            $display("FAIL rstmid_leak: got %0d samples expected 0", got_up.size());
        end
    endtask

    task automatic test_random();
        int eu[$], el[$];
        int m, a, b, c, ru, rl;
        clear_got();
        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 3) != 0) begin
                m = $urandom_range(0, 3);
                a = $urandom_range(0, Q - 1);
                b = $urandom_range(0, Q - 1);
                c = $urandom_range(0, Q - 1);
                drive(1'b1, m, a, b, c);
                if (en) begin
                    ref_bf(m, a, b, c, Q, ru, rl);
                    eu.push_back(ru);
                    el.push_back(rl);
                end
            end else begin
                idle();
            end
            tick();
        end
        en = 1'b1;
        idle();
        for (int k = 0; k < 30 && got_up.size() < eu.size(); k++) tick();
        n_checks++;
        if (got_up.size() != eu.size()) begin
            n_fail++;
            $display("FAIL random_count: got %0d samples expected %0d", got_up.size(), eu.size());
        end
        for (int i = 0; i < got_up.size() && i < eu.size(); i++) begin
            n_checks++;
            if (got_up[i] != eu[i] || got_lo[i] != el[i]) begin
                n_fail++;
                $display("FAIL random_data[%0d]: got %0d/%0d expected %0d/%0d",
                         i, got_up[i], got_lo[i], eu[i], el[i]);
            end
        end
    endtask

    task automatic test_param_sweep();
        int eu[$], el[$], et[$];
        int issued = 0, p1 = 0, p5 = 0;
        int m, a, b, c, ru, rl;
        for (int k = 0; k < SN + 40 && (p1 < SN || p5 < SN); k++) begin
            if (issued < SN) begin
                m = $urandom_range(0, 2);
                a = $urandom_range(0, SQ - 1);
                b = $urandom_range(0, SQ - 1);
                c = $urandom_range(0, SQ - 1);
                ref_bf(m, a, b, c, SQ, ru, rl);
                eu.push_back(ru);
                el.push_back(rl);
                et.push_back(cyc);
                s_valid = 1'b1;
                s_mode  = 2'(m);
                s_u     = 14'(a);
                s_v     = 14'(b);
                s_w     = 14'(c);
                issued++;
            end else begin
                s_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (s1_ov) begin
                n_checks++;
                if (p1 >= SN) begin
                    n_fail++;
                    $display("FAIL sweep1_extra: got unexpected sample at cycle %0d", cyc);
                end else begin
                    if (int'(s1_up) != eu[p1] || int'(s1_lo) != el[p1] || cyc - et[p1] != 3) begin
                        n_fail++;
                        $display("FAIL sweep1[%0d]: got %0d/%0d lat %0d expected %0d/%0d lat 3",
                                 p1, s1_up, s1_lo, cyc - et[p1], eu[p1], el[p1]);
                    end
                    p1++;
                end
            end
            if (s5_ov) begin
                n_checks++;
                if (p5 >= SN) begin
                    n_fail++;
                    $display("FAIL sweep5_extra: got unexpected sample at cycle %0d", cyc);
                end else begin
                    if (int'(s5_up) != eu[p5] || int'(s5_lo) != el[p5] || cyc - et[p5] != 7) begin
                        n_fail++;
                        $display("FAIL sweep5[%0d]: got %0d/%0d lat %0d expected %0d/%0d lat 7",
                                 p5, s5_up, s5_lo, cyc - et[p5], eu[p5], el[p5]);
                    end
                    p5++;
                end
            end
        end
        s_valid = 1'b0;
        n_checks++;
        if (p1 != SN || p5 != SN) begin
            n_fail++;
            $display("FAIL sweep_count: got %0d/%0d samples expected %0d", p1, p5, SN);
        end
    endtask

    initial begin
        rst     = 1'b0;
        en      = 1'b1;
        s_en    = 1'b1;
        s_valid = 1'b0;
        s_mode  = 2'b00;
        s_u     = '0;
        s_v     = '0;
        s_w     = '0;
        drive(1'b0, 0, 0, 0, 0);
        test_reset();
        test_ct();
        test_gs();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_random();
        test_param_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
